// File: rtl/croc_obi_reg_bridge.sv
// OBI subordinate that re-issues each granted transaction as one regbus
// access; a watchdog turns a silent target into an OBI error response.
package croc_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
    int unsigned IdWidth;
    bit          UseRReady;
  } obi_cfg_t;

  localparam obi_cfg_t SbrObiCfg = '{
    AddrWidth: 32, DataWidth: 32, IdWidth: 4, UseRReady: 1'b0
  };

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } sbr_obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        err;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module croc_obi_reg_bridge #(
  parameter croc_pkg::obi_cfg_t ObiCfg = croc_pkg::SbrObiCfg,
  parameter type obi_req_t = croc_pkg::sbr_obi_req_t,
  parameter type obi_rsp_t = croc_pkg::sbr_obi_rsp_t,
  parameter type reg_req_t = croc_pkg::reg_req_t,
  parameter type reg_rsp_t = croc_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [15:0] TO_LAST = 16'(TimeoutCycles - 1);
  localparam logic [31:0] TO_DATA = 32'hBADC_AB1E;

  logic [1:0]                    state_q;
  logic [15:0]                   cnt_q;
  logic [ObiCfg.AddrWidth-1:0]   addr_q;
  logic [ObiCfg.DataWidth-1:0]   wdata_q;
  logic [3:0]                    wstrb_q;
  logic                          write_q;
  logic                          valid_q;
  logic [ObiCfg.IdWidth-1:0]     aid_q;
  logic                          rvalid_q;
  logic [ObiCfg.DataWidth-1:0]   rdata_q;
  logic [ObiCfg.IdWidth-1:0]     rid_q;
  logic                          err_q;
  logic                          gnt;

  // Grant is gated by reset so nothing is accepted while held in reset.
  assign gnt = obi_req_i.req & ~rst_i
             & ((state_q == IDLE) | (state_q == RESP));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      write_q  <= 1'b0;
      valid_q  <= 1'b0;
      aid_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
      err_q    <= 1'b0;
      unique case (state_q)
        ACCESS: begin
          if (reg_rsp_i.ready) begin
            valid_q  <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= write_q ? '0 : reg_rsp_i.rdata;
            err_q    <= reg_rsp_i.error;
            rid_q    <= aid_q;
            state_q  <= RESP;
          end else if (TimeoutCycles != 0 && cnt_q == TO_LAST) begin
            valid_q  <= 1'b0;
            rvalid_q <= 1'b1;
            rdata_q  <= TO_DATA;
            err_q    <= 1'b1;
            rid_q    <= aid_q;
            state_q  <= RESP;
          end else if (cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          if (gnt) begin
            addr_q  <= obi_req_i.addr;
            write_q <= obi_req_i.we;
            wdata_q <= obi_req_i.we ? obi_req_i.wdata : '0;
            wstrb_q <= obi_req_i.we ? obi_req_i.be : 4'b0;
            aid_q   <= obi_req_i.aid;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ACCESS;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = gnt;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.rid    = rid_q;
    obi_rsp_o.err    = err_q;
    reg_req_o        = '0;
    reg_req_o.addr   = addr_q;
    reg_req_o.write  = write_q;
    reg_req_o.wdata  = wdata_q;
    reg_req_o.wstrb  = wstrb_q;
    reg_req_o.valid  = valid_q;
  end
endmodule
